// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - MDU request/result bus; divZero exists only with MDU_DIVZERO_EN
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             hiW;
  logic             loW;
  logic [WIDTH-1:0] wrD;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MDU_DIVZERO_EN
  logic             divZero;

  modport master (output start, op, srcA, srcB, hiW, loW, wrD,
                  input  busy, done, hi, lo, divZero);
  modport slave  (input  start, op, srcA, srcB, hiW, loW, wrD,
                  output busy, done, hi, lo, divZero);
`else
  modport master (output start, op, srcA, srcB, hiW, loW, wrD,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, srcA, srcB, hiW, loW, wrD,
                  output busy, done, hi, lo);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers
// MDU_DIVZERO_EN adds divZero and leaves HI/LO untouched on a divide by zero.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] work;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               busy_q;
  logic               done_q;

  // Operands are iterated as magnitudes; signs are re-applied in FIX.
  logic             sgn_a;
  logic             sgn_b;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign sgn_a = ~bus.op[0] & bus.srcA[WIDTH-1];
  assign sgn_b = ~bus.op[0] & bus.srcB[WIDTH-1];
  assign a_mag = sgn_a ? -bus.srcA : bus.srcA;
  assign b_mag = sgn_b ? -bus.srcB : bus.srcB;

  // Shift-add: work = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, work[WIDTH-1:1]};

  // Restoring divide: work = {remainder, dividend bits / quotient bits}.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
  assign div_sub   = div_shift[WIDTH-1:0] - opnd;
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_next  = {div_ge ? div_sub : div_shift[WIDTH-1:0], work[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_q ? -work : work;
  assign quo_fix  = neg_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
  assign rem_fix  = neg_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

  logic wr_result;
`ifdef MDU_DIVZERO_EN
  logic b_zero;
  logic dz_q;
  assign wr_result   = ~(is_div & b_zero);
  assign bus.divZero = dz_q;
`else
  assign wr_result = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      work   <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef MDU_DIVZERO_EN
      b_zero <= 1'b0;
      dz_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MDU_DIVZERO_EN
      dz_q   <= 1'b0;
`endif
      case (state)
        IDLE, DONE: begin
          // Register writes land even on the edge that accepts a start.
          if (bus.hiW) hi_q <= bus.wrD;
          if (bus.loW) lo_q <= bus.wrD;
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
            cnt    <= '0;
            is_div <= bus.op[1];
            neg_q  <= sgn_a ^ sgn_b;
            neg_r  <= sgn_a;
            work   <= {{WIDTH{1'b0}}, bus.op[1] ? a_mag : b_mag};
            opnd   <= bus.op[1] ? b_mag : a_mag;
`ifdef MDU_DIVZERO_EN
            b_zero <= (bus.srcB == '0);
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work <= is_div ? div_next : mul_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
`ifdef MDU_DIVZERO_EN
          dz_q   <= ~wr_result;
`endif
          if (wr_result) begin
            if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rh, output logic [31:0] rl, output logic dz);
    longint      sa, sb;
    logic [63:0] p;
    rh = exp_hi;
    rl = exp_lo;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o[1] && b == 0) begin
`ifdef MDU_DIVZERO_EN
      dz = 1'b1;
`else
      rl = (o[0] || !a[31]) ? 32'hFFFF_FFFF : 32'h0000_0001;
      rh = a;
`endif
    end else begin
      case (o)
        2'b00: p = 64'(sa * sb);
        2'b01: p = {32'b0, a} * {32'b0, b};
        2'b10: p = {32'(sa % sb), 32'(sa / sb)};
        default: p = {a % b, a / b};
      endcase
      rh = p[63:32];
      rl = p[31:0];
    end
  endtask

  // mode 0: plain; 1: start+hiW attempted at edge 10; 2: hiW on the accepting edge
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int mode);
    int k, busy_cycles;
    logic [31:0] eh, el;
    logic edz;
    bus.start = 1'b1;
    bus.op    = o;
    bus.srcA  = a;
    bus.srcB  = b;
    if (mode == 2) begin
      bus.hiW = 1'b1;
      bus.wrD = 32'hCAFE_0001;
    end
    step();
    bus.start = 1'b0;
    bus.hiW   = 1'b0;
    if (mode == 2) begin
      exp_hi = 32'hCAFE_0001;
      check("wr_with_start", bus.hi, exp_hi);
    end
    busy_cycles = 0;
    k = 0;
    while (!bus.done && k < 40) begin
      if (bus.busy) busy_cycles++;
      if (mode == 1 && k == 9) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.hiW   = 1'b1;
        bus.wrD   = 32'd5;
      end
      step();
      k++;
      bus.start = 1'b0;
      bus.hiW   = 1'b0;
      if (mode == 1 && k == 10) check("hold_hi", bus.hi, exp_hi);
    end
    model(o, a, b, eh, el, edz);
    exp_hi = eh;
    exp_lo = el;
    check("latency", k, 33);
    check("busy_cycles", busy_cycles, 33);
    check("hi", bus.hi, exp_hi);
    check("lo", bus.lo, exp_lo);
`ifdef MDU_DIVZERO_EN
    check("divZero", bus.divZero, edz);
`endif
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.srcA  = '0;
    bus.srcB  = '0;
    bus.hiW   = 1'b0;
    bus.loW   = 1'b0;
    bus.wrD   = '0;
    step();
    step();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    rst = 1'b0;
    step();

    bus.hiW = 1'b1;
    bus.wrD = 32'h1234_5678;
    step();
    bus.hiW = 1'b0;
    exp_hi = 32'h1234_5678;
    check("mthi", bus.hi, exp_hi);
    bus.loW = 1'b1;
    bus.wrD = 32'h9ABC_DEF0;
    step();
    bus.loW = 1'b0;
    exp_lo = 32'h9ABC_DEF0;
    check("mtlo", bus.lo, exp_lo);
    check("mtlo_hi_kept", bus.hi, exp_hi);
    check("mt_no_done", bus.done, 0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_hi_const", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo_const", bus.lo, 32'h0000_0001);
    step();
    check("done_pulse_end", bus.done, 0);
    run_op(2'b00, -32'd7, 32'd6, 0);
    check("mult_lo_const", bus.lo, 32'hFFFF_FFD6);
    run_op(2'b10, -32'd7, 32'd2, 0);
    check("div_lo_const", bus.lo, 32'hFFFF_FFFD);
    check("div_hi_const", bus.hi, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    run_op(2'b11, 32'd100, 32'd0, 0);
    run_op(2'b10, -32'd9, 32'd0, 0);
    run_op(2'b11, 32'd1000, 32'd7, 1);
    check("divu_lo_const", bus.lo, 32'd142);
    check("divu_hi_const", bus.hi, 32'd6);
    run_op(2'b01, 32'd3, 32'd5, 2);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 0);
      if ($urandom_range(0, 1) == 1) step();
    end

    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.srcA  = 32'h0001_2345;
    bus.srcB  = 32'h0000_0777;
    step();
    bus.start = 1'b0;
    repeat (14) step();
    #3;
    rst = 1'b1;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    step();
    rst = 1'b0;
    step();
    run_op(2'b00, 32'h0001_2345, 32'hFFFF_F889, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
